// File: rtl/pipeline_sequencer.sv
// ---------------------------------------------------------------------------
// pipeline_sequencer
//
// Run-control and hazard sequencer for a five-stage pipeline (IF, ID, EX,
// MEM, WB). It starts execution from PC 0, applies the load-use stall and
// branch/jump flush requests raised by ID, drains the pipe after a halt and
// supports single-step debug. A valid bit per pipeline register lets it count
// retired instructions and report completion.
//
// Ports:
//   Clk          pipeline clock, rising edge
//   ResetN       asynchronous active-low reset
//   Start        begin a run (sampled in IDLE and DONE)
//   Halt         ID: instruction in IF/ID is a halt
//   Stall        ID: load-use hazard
//   Branch/Jump  ID: taken redirect
//   StepMode     1 = advance only when Step is high
//   Step         single-cycle advance request
//   PCReset      synchronous clear of the PC register
//   PCEn         PC load enable
//   IFIDEn       IF/ID register enable
//   IFIDFlush    zero IF/ID
//   IDEXBubble   load a NOP into ID/EX
//   PipeEn       EX/MEM and MEM/WB advance enable
//   Busy         state is RUN or DRAIN
//   Done         state is DONE
//   Valid        per-register valid bits, bit 0 = IF/ID
//   RetiredCount instructions retired from WB (wraps)
// ---------------------------------------------------------------------------
module pipeline_sequencer #(
    parameter int STAGES = 5,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              Start,
    input  logic              Halt,
    input  logic              Stall,
    input  logic              Branch,
    input  logic              Jump,
    input  logic              StepMode,
    input  logic              Step,
    output logic              PCReset,
    output logic              PCEn,
    output logic              IFIDEn,
    output logic              IFIDFlush,
    output logic              IDEXBubble,
    output logic              PipeEn,
    output logic              Busy,
    output logic              Done,
    output logic [STAGES-2:0] Valid,
    output logic [CNT_W-1:0]  RetiredCount
);

    localparam int VW = STAGES - 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [VW-1:0] valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic          advance;
    logic [VW-1:0] shifted;

    // Only RUN/DRAIN move the pipe; in step mode each high Step cycle is one move.
    assign advance = ((state_q == S_RUN) || (state_q == S_DRAIN)) && (!StepMode || Step);

    // Every register takes its predecessor; IF/ID gets an empty slot by default.
    assign shifted = {valid_q[VW-2:0], 1'b0};

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        cnt_d      = cnt_q;
        PCEn       = 1'b0;
        IFIDEn     = 1'b0;
        IFIDFlush  = 1'b0;
        IDEXBubble = 1'b0;
        PipeEn     = 1'b0;
        PCReset    = (state_q == S_IDLE) || (state_q == S_DONE);

        if (advance && valid_q[VW-1]) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    state_d = S_RUN;
                    valid_d = '0;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (advance) begin
                    PipeEn = 1'b1;
                    if (Halt) begin
                        // PC freezes; the halt itself moves on to ID/EX and retires.
                        IFIDEn    = 1'b1;
                        IFIDFlush = 1'b1;
                        valid_d   = shifted;
                        state_d   = S_DRAIN;
                    end else if (Stall) begin
                        // IF/ID holds its instruction while a bubble enters ID/EX.
                        IDEXBubble = 1'b1;
                        valid_d    = shifted;
                        valid_d[0] = valid_q[0];
                        valid_d[1] = 1'b0;
                    end else if (Branch || Jump) begin
                        // PC loads the target; the wrong-path fetch is squashed.
                        PCEn      = 1'b1;
                        IFIDEn    = 1'b1;
                        IFIDFlush = 1'b1;
                        valid_d   = shifted;
                    end else begin
                        PCEn       = 1'b1;
                        IFIDEn     = 1'b1;
                        valid_d    = shifted;
                        valid_d[0] = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (advance) begin
                    IFIDEn    = 1'b1;
                    IFIDFlush = 1'b1;
                    PipeEn    = 1'b1;
                    valid_d   = shifted;
                    if (shifted == '0) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign Done         = (state_q == S_DONE);
    assign Valid        = valid_q;
    assign RetiredCount = cnt_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pipeline_sequencer
//
// Scoreboard bench for pipeline_sequencer. Cycle c of a test is the cycle
// after edge c-1; Start is driven in cycle 0. Expected values are queued when
// the corresponding stimulus is driven and checked at the falling edge of the
// cycle they belong to.
// ---------------------------------------------------------------------------
module tb_pipeline_sequencer;

    localparam int STAGES = 5;
    localparam int CNT_W  = 16;

    localparam int SIG_PCRESET = 0;
    localparam int SIG_PCEN    = 1;
    localparam int SIG_IFIDEN  = 2;
    localparam int SIG_FLUSH   = 3;
    localparam int SIG_BUBBLE  = 4;
    localparam int SIG_PIPEEN  = 5;
    localparam int SIG_BUSY    = 6;
    localparam int SIG_DONE    = 7;
    localparam int SIG_VALID   = 8;
    localparam int SIG_CNT     = 9;

    logic              Clk;
    logic              ResetN;
    logic              Start, Halt, Stall, Branch, Jump, StepMode, Step;
    logic              PCReset, PCEn, IFIDEn, IFIDFlush, IDEXBubble, PipeEn, Busy, Done;
    logic [STAGES-2:0] Valid;
    logic [CNT_W-1:0]  RetiredCount;

    typedef struct {
        int cyc;
        int sig;
        int exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    pipeline_sequencer #(.STAGES(STAGES), .CNT_W(CNT_W)) dut (
        .Clk          (Clk),
        .ResetN       (ResetN),
        .Start        (Start),
        .Halt         (Halt),
        .Stall        (Stall),
        .Branch       (Branch),
        .Jump         (Jump),
        .StepMode     (StepMode),
        .Step         (Step),
        .PCReset      (PCReset),
        .PCEn         (PCEn),
        .IFIDEn       (IFIDEn),
        .IFIDFlush    (IFIDFlush),
        .IDEXBubble   (IDEXBubble),
        .PipeEn       (PipeEn),
        .Busy         (Busy),
        .Done         (Done),
        .Valid        (Valid),
        .RetiredCount (RetiredCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic string sname(input int s);
        case (s)
            SIG_PCRESET: return "PCReset";
            SIG_PCEN:    return "PCEn";
            SIG_IFIDEN:  return "IFIDEn";
            SIG_FLUSH:   return "IFIDFlush";
            SIG_BUBBLE:  return "IDEXBubble";
            SIG_PIPEEN:  return "PipeEn";
            SIG_BUSY:    return "Busy";
            SIG_DONE:    return "Done";
            SIG_VALID:   return "Valid";
            default:     return "RetiredCount";
        endcase
    endfunction

    function automatic int observe(input int s);
        case (s)
            SIG_PCRESET: return int'(PCReset);
            SIG_PCEN:    return int'(PCEn);
            SIG_IFIDEN:  return int'(IFIDEn);
            SIG_FLUSH:   return int'(IFIDFlush);
            SIG_BUBBLE:  return int'(IDEXBubble);
            SIG_PIPEEN:  return int'(PipeEn);
            SIG_BUSY:    return int'(Busy);
            SIG_DONE:    return int'(Done);
            SIG_VALID:   return int'(Valid);
            default:     return int'(RetiredCount);
        endcase
    endfunction

    task automatic expect_at(input int cyc, input int sig, input int v);
        exp_t e;
        e.cyc = cyc;
        e.sig = sig;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic clear_inputs();
        Start    = 1'b0;
        Halt     = 1'b0;
        Stall    = 1'b0;
        Branch   = 1'b0;
        Jump     = 1'b0;
        StepMode = 1'b0;
        Step     = 1'b0;
    endtask

    // Drive the inputs of cycle c of test t and queue the results they imply.
    task automatic apply(input int t, input int c);
        Start  = 1'b0;
        Halt   = 1'b0;
        Stall  = 1'b0;
        Branch = 1'b0;
        Jump   = 1'b0;
        Step   = 1'b0;
        if (c == 0) Start = 1'b1;
        case (t)
            1: begin
                if (c == 0) begin
                    expect_at(0, SIG_PCRESET, 1);
                    expect_at(0, SIG_PCEN, 0);
                    expect_at(0, SIG_BUSY, 0);
                    expect_at(1, SIG_PCEN, 1);
                    expect_at(1, SIG_BUSY, 1);
                    expect_at(1, SIG_PCRESET, 0);
                    expect_at(2, SIG_VALID, 1);
                    expect_at(5, SIG_VALID, 15);
                    expect_at(5, SIG_CNT, 0);
                    expect_at(6, SIG_CNT, 1);
                    expect_at(11, SIG_CNT, 6);
                end
            end
            2: begin
                if (c == 0) expect_at(11, SIG_CNT, 5);
                if (c == 6) begin
                    Stall = 1'b1;
                    expect_at(6, SIG_PCEN, 0);
                    expect_at(6, SIG_IFIDEN, 0);
                    expect_at(6, SIG_BUBBLE, 1);
                    expect_at(6, SIG_PIPEEN, 1);
                    expect_at(7, SIG_VALID, 13);
                end
            end
            3, 7: begin
                if (c == 0) begin
                    expect_at(10, SIG_CNT, 5);
                    expect_at(11, SIG_CNT, 5);
                end
                if (c == 6) begin
                    if (t == 3) Branch = 1'b1;
                    else        Jump   = 1'b1;
                    expect_at(6, SIG_FLUSH, 1);
                    expect_at(6, SIG_PCEN, 1);
                    expect_at(6, SIG_IFIDEN, 1);
                    expect_at(7, SIG_VALID, 14);
                end
            end
            4: begin
                if (c == 6) begin
                    Halt = 1'b1;
                    expect_at(6, SIG_PCEN, 0);
                    expect_at(6, SIG_FLUSH, 1);
                    expect_at(7, SIG_BUSY, 1);
                    expect_at(7, SIG_PCRESET, 0);
                    expect_at(9, SIG_DONE, 0);
                    expect_at(10, SIG_DONE, 1);
                    expect_at(10, SIG_BUSY, 0);
                    expect_at(10, SIG_CNT, 5);
                    expect_at(10, SIG_VALID, 0);
                    expect_at(10, SIG_PCRESET, 1);
                    expect_at(11, SIG_PCEN, 0);
                end
                if (c == 7) begin
                    // Hazard requests while draining must not change anything.
                    Stall  = 1'b1;
                    Branch = 1'b1;
                    expect_at(7, SIG_BUBBLE, 0);
                    expect_at(7, SIG_IFIDEN, 1);
                    expect_at(7, SIG_PCEN, 0);
                    expect_at(7, SIG_PIPEEN, 1);
                end
                if (c == 11) begin
                    Start = 1'b1;
                    expect_at(12, SIG_CNT, 0);
                    expect_at(12, SIG_BUSY, 1);
                    expect_at(12, SIG_DONE, 0);
                end
            end
            5: begin
                StepMode = 1'b1;
                if (c == 0) begin
                    expect_at(1, SIG_PCEN, 0);
                    expect_at(1, SIG_PIPEEN, 0);
                    expect_at(1, SIG_BUSY, 1);
                    expect_at(3, SIG_VALID, 1);
                    expect_at(9, SIG_CNT, 0);
                    expect_at(9, SIG_VALID, 15);
                    expect_at(11, SIG_CNT, 1);
                end
                if (c >= 2 && c <= 10 && (c % 2) == 0) begin
                    Step = 1'b1;
                    expect_at(c, SIG_PCEN, 1);
                    expect_at(c, SIG_PIPEEN, 1);
                    expect_at(c + 1, SIG_PCEN, 0);
                end
            end
            6: begin
                if (c == 6) Halt = 1'b1;
            end
            default: ;
        endcase
    endtask

    task automatic score(input int t, input int c);
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == c) begin
                chk($sformatf("t%0d_%s_c%0d", t, sname(sb[i].sig), c),
                    observe(sb[i].sig), sb[i].exp);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        ResetN = 1'b0;
        @(posedge Clk);
        #1;
        ResetN = 1'b1;
    endtask

    task automatic run_test(input int t, input int n);
        for (int c = 0; c < n; c++) begin
            apply(t, c);
            @(negedge Clk);
            score(t, c);
            @(posedge Clk);
            #1;
        end
        chk($sformatf("t%0d_leftover", t), sb.size(), 0);
        sb.delete();
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        ResetN = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_PCReset", int'(PCReset), 1);
        chk("rst_PCEn", int'(PCEn), 0);
        chk("rst_PipeEn", int'(PipeEn), 0);
        chk("rst_Busy", int'(Busy), 0);
        chk("rst_Done", int'(Done), 0);
        chk("rst_Valid", int'(Valid), 0);
        chk("rst_Count", int'(RetiredCount), 0);
        ResetN = 1'b1;

        // Normal run, stall, branch, halt/restart, single-step, jump.
        do_reset(); run_test(1, 12);
        do_reset(); run_test(2, 12);
        do_reset(); run_test(3, 12);
        do_reset(); run_test(4, 13);
        do_reset(); run_test(5, 12);
        do_reset(); run_test(7, 12);

        // Reset asserted mid-DRAIN acts without waiting for a clock edge.
        do_reset(); run_test(6, 8);
        chk("t6_Busy_before_rst", int'(Busy), 1);
        chk("t6_Valid_before_rst", int'(Valid), 12);
        #2;
        ResetN = 1'b0;
        #1;
        chk("t6_Busy_after_rst", int'(Busy), 0);
        chk("t6_Done_after_rst", int'(Done), 0);
        chk("t6_PCReset_after_rst", int'(PCReset), 1);
        chk("t6_Valid_after_rst", int'(Valid), 0);
        chk("t6_Count_after_rst", int'(RetiredCount), 0);
        chk("t6_PCEn_after_rst", int'(PCEn), 0);
        ResetN = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Run-control and hazard sequencer for the five-stage pipeline (IF, ID, EX, MEM, WB). It starts execution from PC 0 and applies the load-use stall and branch/jump flush requests raised by ID. It drains the pipe on a halt and supports single-step debug. It tracks per-register valid bits so it can count retired instructions and signal completion, which replaces a fixed-length run.

## Interface
- STAGES, 5: number of pipeline stages; the valid vector has STAGES-1 bits, one per pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB).
- CNT_W, 16: width of RetiredCount.

Ports:
- Clk  in  1  pipeline clock; all state changes on its rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- Start  in  1  begins a run; sampled in IDLE and DONE.
- Halt  in  1  from ID: the instruction in IF/ID is a halt.
- Stall  in  1  from ID: load-use hazard.
- Branch, Jump  in  1 each  from ID: taken redirect.
- StepMode  in  1  1 = advance only on Step.
- Step  in  1  single-cycle advance request.
- PCReset  out  1  synchronous clear of the PC register.
- PCEn  out  1  PC load enable.
- IFIDEn  out  1  IF/ID register enable.
- IFIDFlush  out  1  zero IF/ID (squash).
- IDEXBubble  out  1  load a NOP into ID/EX.
- PipeEn  out  1  EX/MEM and MEM/WB advance enable.
- Busy  out  1  state is RUN or DRAIN.
- Done  out  1  state is DONE.
- Valid  out  STAGES-1  per-register valid bits; bit 0 is IF/ID.
- RetiredCount  out  CNT_W  instructions retired from WB.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on Start.
  - RUN→DRAIN on Halt, if the cycle advances.
  - DRAIN→DONE on the advance that leaves Valid all-zero.
  - DONE→RUN on Start.
- Reset values: state IDLE; Valid=0; RetiredCount=0; PCReset=1; all enables, flush and bubble 0; Busy=0; Done=0.
- PCReset is 1 in IDLE and DONE, 0 otherwise.
- Start in IDLE/DONE clears RetiredCount and Valid.
- Advance cycle: state RUN or DRAIN, and (StepMode=0 or Step=1).
  - Non-advance cycles drive all enables 0 and hold Valid.
  - In non-advance cycles Halt, Stall, Branch and Jump are ignored.
- RUN advance priority is Halt > Stall > Branch|Jump > normal:
  - Normal: PCEn=IFIDEn=PipeEn=1. Valid shifts up one position; Valid[0]<=1.
  - Stall: PCEn=0, IFIDEn=0, IDEXBubble=1, PipeEn=1. Valid[0] holds; Valid[1]<=0; upper bits shift.
  - Branch|Jump: PCEn=1 (loads the target), IFIDEn=1, IFIDFlush=1, PipeEn=1. Valid[0]<=0; the rest shift.
  - Halt: PCEn=0, IFIDEn=1, IFIDFlush=1, PipeEn=1. Valid[0]<=0; the rest shift, so the halt instruction moves to ID/EX and retires.
- DRAIN advance: PCEn=0, IFIDEn=1, IFIDFlush=1, PipeEn=1. Shift with Valid[0]<=0. Stall, Branch, Jump and Halt are ignored.
- Retire: RetiredCount increments on any advance with Valid[top]=1. It wraps modulo 2^CNT_W.
- Start while RUN/DRAIN is ignored.
- ResetN low at any time, including mid-DRAIN, forces reset values immediately (asynchronous).

## Timing
- Control outputs (enables, flush, bubble, PCReset) are combinational from state and inputs; they are valid in the same cycle the ID requests arrive.
- Valid, RetiredCount, Busy and Done are registered.
- Start sampled at edge 0:
  - first fetch (PC 0) occurs in cycle 1;
  - Valid[0]=1 after edge 1;
  - first retire is counted at edge 5, so latency is STAGES advances.
- A stall delays every later retirement by exactly one advance.
- Halt accepted at edge k: the halt instruction retires at advance k+3, and Done=1 from that same edge.
- In step mode each Step pulse equals one advance. Step held high for N cycles equals N advances.

## Test plan
- Reset, Start, no hazards for 10 cycles → RetiredCount=6 after edge 10; Valid=4'b1111 from edge 4.
- Stall high in cycle 6 → that cycle PCEn=0, IFIDEn=0, IDEXBubble=1, PipeEn=1; after edge 10 RetiredCount=5.
- Branch high in cycle 6 → IFIDFlush=1, PCEn=1; after edge 6 Valid[0]=0; the squashed slot never increments RetiredCount.
- Halt high in cycle 6 → DRAIN from cycle 7; Done=1 and Busy=0 after edge 9; final RetiredCount=5. Start then → RetiredCount=0 and RUN.
- StepMode=1, Start, 5 Step pulses separated by idle cycles → enables high only in Step cycles; RetiredCount=0 after pulse 4 and 1 after pulse 5.
- ResetN low during DRAIN → immediately IDLE, Valid=0, RetiredCount=0, PCReset=1, Busy=0, Done=0.
